spi_reg_sequencer: RTL and testbench

SPI_REG_SEQUENCER -- requirements
Module: spi_reg_sequencer

---
 rtl/spi_cfg_pkg.sv | 10 +
 rtl/spi_frame_shifter.sv | 63 ++++++
 rtl/spi_reg_sequencer.sv | 119 +++++++++++
 tb/tb_spi_reg_sequencer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/spi_cfg_pkg.sv
// spi_cfg_pkg: shared state encoding and constants for the SPI register sequencer
package spi_cfg_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SHIFT, S_GAP, S_RD_CMD, S_RD_SHIFT, S_RD_GAP, S_DONE
  } state_e;
  localparam logic [3:0] RD_CMD_DEF = 4'hE;
  function automatic int frame_len(input int dw, input int div);
    return dw * 2 * div;
  endfunction
endpackage

// File: rtl/spi_frame_shifter.sv
// spi_frame_shifter: one full-duplex DATA_W-bit SPI frame with start/done handshake
module spi_frame_shifter
  import spi_cfg_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int CLK_DIV   = 4,
  parameter int LSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_miso,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_sclk,
  output logic              o_mosi,
  output logic              o_le,
  output logic [DATA_W-1:0] o_rdata
);
  localparam int DIVW = $clog2(2 * CLK_DIV);
  localparam int BW   = $clog2(DATA_W + 1);
  logic              r_act;
  logic [DIVW-1:0]   r_div;
  logic [BW-1:0]     r_bit;
  logic [DATA_W-1:0] r_tx, r_rx;
  logic              w_eob, w_smp, w_last;
  assign w_eob   = r_div == DIVW'(2 * CLK_DIV - 1);
  assign w_smp   = r_div == DIVW'(CLK_DIV - 1);
  assign w_last  = r_bit == BW'(DATA_W - 1);
  assign o_busy  = r_act;
  assign o_done  = r_act && w_eob && w_last;
  assign o_sclk  = r_act && (r_div >= DIVW'(CLK_DIV));
  assign o_mosi  = r_act && (LSB_FIRST != 0 ? r_tx[0] : r_tx[DATA_W-1]);
  assign o_le    = !r_act;
  assign o_rdata = r_rx;
  // miso is captured on the clock edge that raises spi_clk
  always_ff @(posedge clk) begin
    if (rst) begin
      r_act <= 1'b0;
      r_div <= '0;
      r_bit <= '0;
      r_tx  <= '0;
      r_rx  <= '0;
    end else if (!r_act) begin
      if (i_start) begin
        r_act <= 1'b1;
        r_div <= '0;
        r_bit <= '0;
        r_tx  <= i_data;
      end
    end else begin
      r_div <= w_eob ? '0 : r_div + DIVW'(1);
      if (w_smp)
        r_rx <= LSB_FIRST != 0 ? {i_miso, r_rx[DATA_W-1:1]} : {r_rx[DATA_W-2:0], i_miso};
      if (w_eob) begin
        r_tx  <= LSB_FIRST != 0 ? r_tx >> 1 : r_tx << 1;
        r_bit <= r_bit + BW'(1);
        r_act <= !w_last;
      end
    end
  end
endmodule

// File: rtl/spi_reg_sequencer.sv
// spi_reg_sequencer: streams a register table over SPI with optional readback verify
module spi_reg_sequencer
  import spi_cfg_pkg::*;
#(
  parameter int              DATA_W     = 32,
  parameter int              NUM_REGS   = 16,
  parameter int              CLK_DIV    = 4,
  parameter int              GAP_CYCLES = 600,
  parameter int              LSB_FIRST  = 1,
  parameter logic [3:0]      RD_CMD     = RD_CMD_DEF,
  parameter logic [DATA_W-1:0] CMP_MASK = {DATA_W{1'b1}} << 4,
  localparam int             AW         = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AW:0]       num_words,
  input  logic              verify_en,
  input  logic              tbl_we,
  input  logic [AW-1:0]     tbl_addr,
  input  logic [DATA_W-1:0] tbl_wdata,
  output logic              busy,
  output logic              done,
  output logic              spi_clk,
  output logic              spi_mosi,
  output logic              spi_le,
  input  logic              spi_miso,
  output logic              spi_syn,
  output logic              spi_powerdn,
  output logic              rd_valid,
  output logic [AW-1:0]     rd_index,
  output logic [DATA_W-1:0] rd_data,
  output logic              err,
  output logic [7:0]        err_cnt
);
  localparam int CW = $clog2(GAP_CYCLES);
  state_e            r_state;
  logic [AW:0]       r_n;
  logic [AW-1:0]     r_idx;
  logic [CW-1:0]     r_cnt;
  logic              r_ver, r_cap;
  logic [DATA_W-1:0] r_tbl [NUM_REGS];
  logic              w_go, w_sh_busy, w_sh_done, w_gap_end, w_last, w_mis;
  logic [DATA_W-1:0] w_tx, w_rdata, w_cmd;
  assign w_cmd       = DATA_W'({4'(r_idx), RD_CMD});
  assign w_go        = r_state == S_LOAD || ((r_state == S_RD_CMD || r_state == S_RD_SHIFT) && !w_sh_busy);
  assign w_tx        = r_state == S_LOAD ? r_tbl[r_idx] : r_state == S_RD_CMD ? w_cmd : '0;
  assign w_gap_end   = r_cnt == CW'(GAP_CYCLES - 2);
  assign w_last      = {1'b0, r_idx} == r_n - (AW+1)'(1);
  assign w_mis       = |((w_rdata ^ r_tbl[r_idx]) & CMP_MASK);
  assign busy        = r_state != S_IDLE && r_state != S_DONE;
  assign done        = r_state == S_DONE;
  assign spi_syn     = 1'b1;
  assign spi_powerdn = 1'b1;
  spi_frame_shifter #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .LSB_FIRST(LSB_FIRST)) u_shift (
    .clk(clk), .rst(rst), .i_start(w_go), .i_data(w_tx), .i_miso(spi_miso),
    .o_busy(w_sh_busy), .o_done(w_sh_done), .o_sclk(spi_clk), .o_mosi(spi_mosi),
    .o_le(spi_le), .o_rdata(w_rdata)
  );
  always_ff @(posedge clk)
    if (tbl_we && !busy) r_tbl[tbl_addr] <= tbl_wdata;
  // gap states last GAP_CYCLES-1 cycles; the launch cycle that follows completes the gap
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_n      <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_ver    <= 1'b0;
      r_cap    <= 1'b0;
      rd_valid <= 1'b0;
      rd_index <= '0;
      rd_data  <= '0;
      err      <= 1'b0;
      err_cnt  <= '0;
    end else begin
      rd_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_n     <= num_words > (AW+1)'(NUM_REGS) ? (AW+1)'(NUM_REGS) : num_words;
          r_ver   <= verify_en;
          r_idx   <= '0;
          err     <= 1'b0;
          err_cnt <= '0;
          r_state <= num_words == '0 ? S_DONE : S_LOAD;
        end
        S_LOAD: r_state <= S_SHIFT;
        S_SHIFT: if (w_sh_done) begin
          r_cnt   <= '0;
          r_state <= S_GAP;
        end
        S_GAP: if (w_gap_end) begin
          r_idx   <= w_last ? '0 : r_idx + AW'(1);
          r_state <= !w_last ? S_LOAD : r_ver ? S_RD_CMD : S_DONE;
        end else r_cnt <= r_cnt + CW'(1);
        S_RD_CMD: if (w_sh_done) begin
          r_cnt   <= '0;
          r_cap   <= 1'b0;
          r_state <= S_RD_GAP;
        end
        S_RD_SHIFT: if (w_sh_done) begin
          r_cnt    <= '0;
          r_cap    <= 1'b1;
          r_state  <= S_RD_GAP;
          rd_valid <= 1'b1;
          rd_index <= r_idx;
          rd_data  <= w_rdata;
          err      <= err | w_mis;
          err_cnt  <= w_mis && !(&err_cnt) ? err_cnt + 8'd1 : err_cnt;
        end
        S_RD_GAP: if (w_gap_end) begin
          r_idx   <= r_cap && !w_last ? r_idx + AW'(1) : r_idx;
          r_state <= !r_cap ? S_RD_SHIFT : w_last ? S_DONE : S_RD_CMD;
        end else r_cnt <= r_cnt + CW'(1);
        S_DONE: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_reg_sequencer.sv
// tb_spi_reg_sequencer: directed vectors with a passive SPI monitor and echoing slave model
module tb_spi_reg_sequencer;
  localparam int DW = 32, AW = 4, G = 20;
  logic clk = 0, rst = 1, start = 0, verify_en = 0, tbl_we = 0, spi_miso = 0;
  logic [AW:0] num_words = '0;
  logic [AW-1:0] tbl_addr = '0;
  logic [DW-1:0] tbl_wdata = '0;
  logic busy, done, spi_clk, spi_mosi, spi_le, spi_syn, spi_powerdn, rd_valid, err;
  logic [AW-1:0] rd_index;
  logic [DW-1:0] rd_data;
  logic [7:0] err_cnt;
  spi_reg_sequencer #(.DATA_W(DW), .NUM_REGS(16), .CLK_DIV(2), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words), .verify_en(verify_en),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata), .busy(busy), .done(done),
    .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_le(spi_le), .spi_miso(spi_miso),
    .spi_syn(spi_syn), .spi_powerdn(spi_powerdn), .rd_valid(rd_valid), .rd_index(rd_index),
    .rd_data(rd_data), .err(err), .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  int n_vec = 0, n_bad = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  logic [DW-1:0] resp [16];
  logic [DW-1:0] words [64];
  int lens [64], gaps [64];
  int frames = 0, lo_cnt = 0, hi_cnt = 0, rises = 0, k = 0, bad_idle = 0, done_hi = 0, rdv_n = 0;
  logic [DW-1:0] cur_w = '0, cur_resp = '0, last_word = '0;
  logic prev_sclk = 0;
  logic [AW-1:0] rdv_idx [8];
  logic [DW-1:0] rdv_dat [8];
  logic rdv_err [8];
  // slave model: after a readback command, the next frame returns resp[addr]
  always @(negedge clk) begin
    if (spi_le) begin
      if (spi_clk || spi_mosi) bad_idle++;
      if (lo_cnt != 0) begin
        lens[frames%64] = lo_cnt;
        words[frames%64] = cur_w;
        last_word = cur_w;
        frames++;
      end
      lo_cnt = 0;
      hi_cnt++;
    end else begin
      if (lo_cnt == 0) begin
        gaps[frames%64] = hi_cnt;
        rises = 0;
        k = 0;
        cur_resp = (last_word[31:8] == 0 && last_word[3:0] == 4'hE) ? resp[last_word[7:4]] : '0;
      end
      if (spi_clk && !prev_sclk) begin
        cur_w = {spi_mosi, cur_w[31:1]};
        rises++;
      end
      if (!spi_clk && prev_sclk) k++;
      lo_cnt++;
      hi_cnt = 0;
    end
    prev_sclk = spi_clk;
    spi_miso = !spi_le && k < 32 ? cur_resp[k] : 1'b0;
    if (done) done_hi = hi_cnt;
    if (rd_valid) begin
      rdv_idx[rdv_n%8] = rd_index;
      rdv_dat[rdv_n%8] = rd_data;
      rdv_err[rdv_n%8] = err;
      rdv_n++;
    end
  end
  task automatic wr(input int a, input logic [DW-1:0] d);
    @(negedge clk);
    tbl_we = 1; tbl_addr = AW'(a); tbl_wdata = d;
    @(negedge clk);
    tbl_we = 0;
  endtask
  task automatic launch(input int n, input logic v);
    @(negedge clk);
    num_words = (AW+1)'(n); verify_en = v; start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic wait_done(input string tag);
    int c = 0;
    while (!done && c < 20000) begin
      @(negedge clk);
      c++;
    end
    check(tag, done, 1);
    @(negedge clk);
  endtask
  int b, rb;
  initial begin
    repeat (3) @(negedge clk);
    check("rst_ctl", {spi_le, spi_clk, spi_mosi, busy, done, rd_valid, err}, 7'b1000000);
    check("rst_data", {rd_data, rd_index, err_cnt}, 0);
    check("tied_hi", {spi_syn, spi_powerdn}, 2'b11);
    rst = 0;
    wr(0, 32'h81400320);
    wr(1, 32'h81400301);
    resp[0] = 32'h81400320;
    resp[1] = 32'h81400301;
    b = frames;
    launch(2, 0);
    check("busy_run", busy, 1);
    wait_done("wr_done");
    check("wr_frames", frames - b, 2);
    check("wr_len0", lens[b%64], 128);
    check("wr_len1", lens[(b+1)%64], 128);
    check("wr_word0", words[b%64], 32'h81400320);
    check("wr_word1", words[(b+1)%64], 32'h81400301);
    check("wr_gap", gaps[(b+1)%64], G);
    check("done_gap", done_hi, G);
    check("busy_after", busy, 0);
    b = frames;
    launch(0, 0);
    check("zero_done", {done, busy}, 2'b10);
    @(negedge clk);
    check("zero_pulse", done, 0);
    check("zero_frames", frames - b, 0);
    b = frames; rb = rdv_n;
    launch(2, 1);
    wait_done("vf_done");
    check("vf_frames", frames - b, 6);
    check("vf_cmd0", words[(b+2)%64], 32'h0000000E);
    check("vf_cap0", words[(b+3)%64], 0);
    check("vf_cmd1", words[(b+4)%64], 32'h0000001E);
    check("vf_strobes", rdv_n - rb, 2);
    check("vf_idx", {rdv_idx[rb%8], rdv_idx[(rb+1)%8]}, 8'h01);
    check("vf_dat0", rdv_dat[rb%8], 32'h81400320);
    check("vf_dat1", rdv_dat[(rb+1)%8], 32'h81400301);
    check("vf_err", {err, err_cnt}, 0);
    resp[1] = 32'h81400201;
    rb = rdv_n;
    launch(2, 1);
    wait_done("mis_done");
    check("mis_err", {err, err_cnt}, {1'b1, 8'd1});
    check("mis_strobe_err", {rdv_err[rb%8], rdv_err[(rb+1)%8]}, 2'b01);
    check("mis_idx", rdv_idx[(rb+1)%8], 1);
    check("mis_dat", rdv_dat[(rb+1)%8], 32'h81400201);
    launch(2, 0);
    check("err_clr", {err, err_cnt}, 0);
    for (int c = 0; c < 200 && spi_le; c++) @(negedge clk);
    @(negedge clk);
    for (int c = 0; c < 200 && rises < 11; c++) @(negedge clk);
    check("mid_frame", {spi_le, rises >= 11}, 2'b01);
    rst = 1;
    @(negedge clk);
    check("rst_mid", {spi_le, spi_clk, spi_mosi, busy, done}, 5'b10000);
    rst = 0;
    @(negedge clk);
    b = frames;
    launch(2, 0);
    wait_done("post_rst_done");
    check("post_rst_frames", frames - b, 2);
    check("post_rst_words", {words[b%64], words[(b+1)%64]}, {32'h81400320, 32'h81400301});
    b = frames;
    launch(2, 0);
    repeat (40) @(negedge clk);
    check("busy_ign", busy, 1);
    start = 1; tbl_we = 1; tbl_addr = 0; tbl_wdata = 32'hDEADBEEF;
    @(negedge clk);
    start = 0; tbl_we = 0;
    wait_done("ign_done");
    check("ign_frames", frames - b, 2);
    check("ign_word0", words[b%64], 32'h81400320);
    b = frames;
    launch(1, 0);
    wait_done("tbl_done");
    check("tbl_kept", {frames - b, words[b%64]}, {32'd1, 32'h81400320});
    for (int i = 2; i < 16; i++) wr(i, 32'h10000000 + i);
    b = frames;
    launch(31, 0);
    wait_done("clamp_done");
    check("clamp_frames", frames - b, 16);
    check("clamp_w2", words[(b+2)%64], 32'h10000002);
    check("clamp_w15", words[(b+15)%64], 32'h1000000F);
    check("idle_lines", bad_idle, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
